// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit controller and its lane logic.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  // Wide enough for the largest supported TIMEOUT (65535).
  localparam int unsigned TMO_W = 16;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    return ((size == SZ_HALF) && lo[0]) || ((size == SZ_WORD) && (lo != 2'b00));
  endfunction

  // Byte lane of the access; address bits below the access size are ignored.
  function automatic logic [1:0] lane_off(input logic [1:0] size, input logic [1:0] lo);
    logic [1:0] off;
    case (size)
      SZ_BYTE: off = lo;
      SZ_HALF: off = {lo[1], 1'b0};
      default: off = 2'b00;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response and memory-bus signals of the LSU; slave is the controller side.
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] LW;
  logic [7:0]  LB;
  logic [7:0]  LBU;
  logic [15:0] LH;
  logic [15:0] LHU;

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata,
    output mem_ready, mem_rvalid, mem_rdata,
    input  req_ready, mem_valid, mem_we, mem_addr, mem_wdata, mem_be,
    input  rsp_valid, rsp_err, LW, LB, LBU, LH, LHU
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata,
    input  mem_ready, mem_rvalid, mem_rdata,
    output req_ready, mem_valid, mem_we, mem_addr, mem_wdata, mem_be,
    output rsp_valid, rsp_err, LW, LB, LBU, LH, LHU
  );
endinterface

// File: rtl/lsu_lane.sv
// Combinational lane logic: byte enables, store-data replication, load-lane extraction.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] lw,
  output logic [7:0]  lb,
  output logic [15:0] lh
);

  logic [1:0] off;

  always_comb begin
    off       = lane_off(size, addr_lo);
    be        = 4'b1111;
    wdata_rep = wdata;
    lw        = rdata;
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << off;
        wdata_rep = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be        = 4'b0011 << off;
        wdata_rep = {2{wdata[15:0]}};
      end
      default: ;
    endcase
    case (off)
      2'd0:    lb = rdata[7:0];
      2'd1:    lb = rdata[15:8];
      2'd2:    lb = rdata[23:16];
      default: lb = rdata[31:24];
    endcase
    lh = off[1] ? rdata[31:16] : rdata[15:0];
  end

endmodule

// File: rtl/lsu_ctrl.sv
// LSU controller: request FSM, memory handshake, response timeout and load-lane registers.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned half/word accesses with rsp_err.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  lsu_if.slave bus
);

  state_e            state_q, state_d;
  logic              we_q;
  logic [1:0]        size_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic              err_q;
  logic [TMO_W-1:0]  cnt_q;
  logic [31:0]       lw_q;
  logic [7:0]        lb_q;
  logic [15:0]       lh_q;

  logic              trap;
  logic              timeout_hit;
  logic [3:0]        lane_be;
  logic [31:0]       lane_wdata;
  logic [31:0]       lane_lw;
  logic [7:0]        lane_lb;
  logic [15:0]       lane_lh;

  lsu_lane u_lane (
    .size      (size_q),
    .addr_lo   (addr_q[1:0]),
    .wdata     (wdata_q),
    .rdata     (bus.mem_rdata),
    .be        (lane_be),
    .wdata_rep (lane_wdata),
    .lw        (lane_lw),
    .lb        (lane_lb),
    .lh        (lane_lh)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = misaligned(bus.req_size, bus.req_addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  // cnt_q counts completed WAIT cycles, so this is the last allowed one.
  assign timeout_hit = (cnt_q == TMO_W'(TIMEOUT - 1));

  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_be    = '0;
    bus.rsp_valid = 1'b0;
    bus.rsp_err   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_d = trap ? ST_RESP : ST_ISSUE;
      end
      ST_ISSUE: begin
        bus.mem_valid = 1'b1;
        bus.mem_we    = we_q;
        bus.mem_addr  = {addr_q[31:2], 2'b00};
        bus.mem_wdata = lane_wdata;
        bus.mem_be    = lane_be;
        if (bus.mem_ready) state_d = we_q ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.mem_rvalid || timeout_hit) state_d = ST_RESP;
      end
      ST_RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_err   = err_q;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      lw_q    <= '0;
      lb_q    <= '0;
      lh_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            size_q  <= bus.req_size;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            err_q   <= trap;
            cnt_q   <= '0;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q + TMO_W'(1);
          if (bus.mem_rvalid) begin
            lw_q <= lane_lw;
            lb_q <= lane_lb;
            lh_q <= lane_lh;
          end else if (timeout_hit) begin
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.LW  = lw_q;
  assign bus.LB  = lb_q;
  assign bus.LBU = lb_q;
  assign bus.LH  = lh_q;
  assign bus.LHU = lh_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed vector table, reset-in-WAIT sequence, randomized traffic vs reference model.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  localparam int TMO   = 4;
  localparam int NEVER = 99;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_if bus();

  lsu_ctrl #(.TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          rdly;
    int          vdly;
    logic        exp_mv;
    logic [31:0] exp_maddr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    int          exp_lat;
    logic        exp_err;
    logic [31:0] exp_lw;
    logic [7:0]  exp_lb;
    logic [15:0] exp_lh;
  } vec_t;

  typedef struct {
    logic        mv;
    logic [31:0] maddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic        stable;
    int          lat;
    logic        err;
  } obs_t;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
  endtask

  // Reference: access covers nb bytes starting at the size-aligned lane; store lanes repeat the low nb bytes.
  function automatic vec_t predict(input vec_t t, input logic [31:0] lw, input logic [7:0] lb,
                                   input logic [15:0] lh);
    vec_t p;
    int nb, off;
    bit trap, tmo;
    logic [31:0] sh;
    p    = t;
    nb   = (t.size == 2'd3) ? 4 : (1 << t.size);
    off  = int'(t.addr[1:0]) & ~(nb - 1);
    trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = (nb == 2 && t.addr[0]) || (t.size == 2'd2 && t.addr[1:0] != 2'b00);
`endif
    tmo = !t.we && (t.vdly >= TMO);
    p.exp_mv    = !trap;
    p.exp_maddr = {t.addr[31:2], 2'b00};
    p.exp_be    = '0;
    p.exp_wdata = '0;
    for (int i = 0; i < 4; i++) begin
      if (i >= off && i < off + nb) p.exp_be[i] = 1'b1;
      p.exp_wdata[8*i +: 8] = t.wdata[8*(i % nb) +: 8];
    end
    if (trap)      p.exp_lat = 1;
    else if (t.we) p.exp_lat = t.rdly + 2;
    else if (tmo)  p.exp_lat = t.rdly + TMO + 2;
    else           p.exp_lat = t.rdly + t.vdly + 3;
    p.exp_err = trap || tmo;
    p.exp_lw = lw;
    p.exp_lb = lb;
    p.exp_lh = lh;
    if (!trap && !t.we && !tmo) begin
      p.exp_lw = t.rdata;
      sh = t.rdata >> (8 * off);
      p.exp_lb = sh[7:0];
      sh = t.rdata >> (8 * (off & 2));
      p.exp_lh = sh[15:0];
    end
    return p;
  endfunction

  task automatic clear_inputs();
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge where rsp_valid is seen.
  task automatic do_txn(input vec_t t, output obs_t o);
    int mv_cnt, hs_c;
    bit hs;
    o.mv = 1'b0; o.maddr = '0; o.be = '0; o.wdata = '0; o.we = 1'b0;
    o.stable = 1'b1; o.lat = -1; o.err = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_we    = t.we;
    bus.req_size  = t.size;
    bus.req_addr  = t.addr;
    bus.req_wdata = t.wdata;
    @(negedge clk);
    bus.req_valid = 1'b0;
    mv_cnt = 0; hs = 1'b0; hs_c = 0;
    for (int c = 1; c <= 64; c++) begin
      bus.mem_ready  = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = ~t.rdata;
      if (bus.rsp_valid) begin
        o.lat = c;
        o.err = bus.rsp_err;
        break;
      end
      if (bus.mem_valid && !hs) begin
        if (!o.mv) begin
          o.mv = 1'b1; o.maddr = bus.mem_addr; o.be = bus.mem_be;
          o.wdata = bus.mem_wdata; o.we = bus.mem_we;
        end else if (bus.mem_addr !== o.maddr || bus.mem_be !== o.be ||
                     bus.mem_wdata !== o.wdata || bus.mem_we !== o.we) begin
          o.stable = 1'b0;
        end
        if (mv_cnt == t.rdly) begin
          bus.mem_ready = 1'b1;
          hs = 1'b1;
          hs_c = c;
        end
        mv_cnt++;
      end else if (hs && !t.we && t.vdly < TMO && c == hs_c + 1 + t.vdly) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = t.rdata;
      end
      @(negedge clk);
    end
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
  endtask

  task automatic check_txn(input string tag, input vec_t e, input obs_t o);
    chk({tag, ".mem_valid"}, 32'(o.mv), 32'(e.exp_mv));
    if (e.exp_mv) begin
      chk({tag, ".mem_addr"}, o.maddr, e.exp_maddr);
      chk({tag, ".mem_be"}, 32'(o.be), 32'(e.exp_be));
      chk({tag, ".mem_we"}, 32'(o.we), 32'(e.we));
      chk({tag, ".stable"}, 32'(o.stable), 32'd1);
      if (e.we) chk({tag, ".mem_wdata"}, o.wdata, e.exp_wdata);
    end
    chk({tag, ".latency"}, 32'(o.lat), 32'(e.exp_lat));
    chk({tag, ".rsp_err"}, 32'(o.err), 32'(e.exp_err));
    chk({tag, ".LW"}, bus.LW, e.exp_lw);
    chk({tag, ".LB"}, 32'(bus.LB), 32'(e.exp_lb));
    chk({tag, ".LBU"}, 32'(bus.LBU), 32'(e.exp_lb));
    chk({tag, ".LH"}, 32'(bus.LH), 32'(e.exp_lh));
    chk({tag, ".LHU"}, 32'(bus.LHU), 32'(e.exp_lh));
    @(negedge clk);
    chk({tag, ".rsp_one_cycle"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
    chk({tag, ".mem_valid"}, 32'(bus.mem_valid), 32'd0);
    chk({tag, ".mem_we"}, 32'(bus.mem_we), 32'd0);
    chk({tag, ".mem_be"}, 32'(bus.mem_be), 32'd0);
    chk({tag, ".mem_addr"}, bus.mem_addr, 32'd0);
    chk({tag, ".mem_wdata"}, bus.mem_wdata, 32'd0);
    chk({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, ".rsp_err"}, 32'(bus.rsp_err), 32'd0);
    chk({tag, ".LW"}, bus.LW, 32'd0);
    chk({tag, ".LB"}, 32'(bus.LB), 32'd0);
    chk({tag, ".LH"}, 32'(bus.LH), 32'd0);
  endtask

  vec_t        vecs [9];
  vec_t        t, p;
  obs_t        o;
  logic [31:0] m_lw;
  logic [7:0]  m_lb;
  logic [15:0] m_lh;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          we    size     addr          wdata         rdata         rd vd     mv    maddr         be       wdata         lat err  lw            lb     lh
    vecs[0] = '{1'b0, 2'b00, 32'h0000_1003, 32'h0,        32'hA1B2_C3D4, 0, 0,     1'b1, 32'h0000_1000, 4'b1000, 32'h0,        3, 1'b0, 32'hA1B2_C3D4, 8'hA1, 16'hA1B2};
    vecs[1] = '{1'b1, 2'b01, 32'h0000_2002, 32'h0000_BEEF, 32'h0,        0, 0,     1'b1, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 2, 1'b0, 32'hA1B2_C3D4, 8'hA1, 16'hA1B2};
    vecs[2] = '{1'b0, 2'b10, 32'h0000_4000, 32'h0,        32'h1234_5678, 5, 0,     1'b1, 32'h0000_4000, 4'b1111, 32'h0,        8, 1'b0, 32'h1234_5678, 8'h78, 16'h5678};
    vecs[3] = '{1'b0, 2'b10, 32'h0000_5000, 32'h0,        32'h0,         0, NEVER, 1'b1, 32'h0000_5000, 4'b1111, 32'h0,        6, 1'b1, 32'h1234_5678, 8'h78, 16'h5678};
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[4] = '{1'b0, 2'b10, 32'h0000_3001, 32'h0,        32'hCAFE_F00D, 0, 0,     1'b0, 32'h0,         4'b0000, 32'h0,        1, 1'b1, 32'h1234_5678, 8'h78, 16'h5678};
`else
    vecs[4] = '{1'b0, 2'b10, 32'h0000_3001, 32'h0,        32'hCAFE_F00D, 0, 0,     1'b1, 32'h0000_3000, 4'b1111, 32'h0,        3, 1'b0, 32'hCAFE_F00D, 8'h0D, 16'hF00D};
`endif
    vecs[5] = '{1'b0, 2'b01, 32'h0000_6006, 32'h0,        32'h89AB_CDEF, 0, TMO-1, 1'b1, 32'h0000_6004, 4'b1100, 32'h0,        6, 1'b0, 32'h89AB_CDEF, 8'hAB, 16'h89AB};
    vecs[6] = '{1'b1, 2'b00, 32'h0000_7001, 32'h0000_005A, 32'h0,        2, 0,     1'b1, 32'h0000_7000, 4'b0010, 32'h5A5A_5A5A, 4, 1'b0, 32'h89AB_CDEF, 8'hAB, 16'h89AB};
    vecs[7] = '{1'b0, 2'b00, 32'h0000_8002, 32'h0,        32'h1122_3344, 0, 1,     1'b1, 32'h0000_8000, 4'b0100, 32'h0,        4, 1'b0, 32'h1122_3344, 8'h22, 16'h1122};
    vecs[8] = '{1'b1, 2'b10, 32'h0000_9000, 32'hDEAD_BEEF, 32'h0,        1, 0,     1'b1, 32'h0000_9000, 4'b1111, 32'hDEAD_BEEF, 3, 1'b0, 32'h1122_3344, 8'h22, 16'h1122};

    clear_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      do_txn(vecs[i], o);
      check_txn($sformatf("vec%0d", i), vecs[i], o);
    end

    // Reset while a load is waiting for read data; a late rvalid must be ignored.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'b10;
    bus.req_addr  = 32'h0000_A000;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rstwait.issue", 32'(bus.mem_valid), 32'd1);
    bus.mem_ready = 1'b1;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    chk("rstwait.in_wait", 32'(bus.mem_valid | bus.rsp_valid | bus.req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_values("rstwait");
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rstwait.late%0d.rsp_valid", k), 32'(bus.rsp_valid), 32'd0);
      chk($sformatf("rstwait.late%0d.LW", k), bus.LW, 32'd0);
      @(negedge clk);
    end
    m_lw = '0;
    m_lb = '0;
    m_lh = '0;

    for (int n = 0; n < 80; n++) begin
      int r;
      t.we    = 1'($urandom_range(0, 1));
      t.size  = 2'($urandom_range(0, 3));
      t.addr  = $urandom;
      t.wdata = $urandom;
      t.rdata = $urandom;
      t.rdly  = $urandom_range(0, 3);
      r       = $urandom_range(0, 9);
      t.vdly  = (r < 7) ? int'($urandom_range(0, 2)) : ((r < 8) ? TMO - 1 : NEVER);
      p = predict(t, m_lw, m_lb, m_lh);
      do_txn(t, o);
      check_txn($sformatf("rnd%0d", n), p, o);
      m_lw = p.exp_lw;
      m_lb = p.exp_lb;
      m_lh = p.exp_lh;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
